// File: rtl/pipereg_pkg.sv
// -----------------------------------------------------------------------------
// pipereg_pkg
// Shared definitions for the elastic pipeline register family.
//   - pipereg_occ_t : occupancy of the two-entry skid variant
//   - PIPEREG_*_W   : default payload / counter widths used by pipereg_elastic
// No ports (package only).
// -----------------------------------------------------------------------------
package pipereg_pkg;

   // Default widths for a stage boundary; each instance may override them.
   localparam int PIPEREG_DATA_W = 32;
   localparam int PIPEREG_CTRL_W = 16;
   localparam int PIPEREG_CNT_W  = 16;

   // How many payloads the skid variant currently holds.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } pipereg_occ_t;

endpackage

// File: rtl/pipereg_skid_buf.sv
// -----------------------------------------------------------------------------
// pipereg_skid_buf
// Skid entry plus occupancy FSM for the two-entry variant of pipereg_elastic.
// The main (output) entry lives in the top level; this block tells the top
// when to load the main entry from the input, from the skid entry, or clear it.
// Only instantiated when PIPEREG_SKID_EN is defined.
//
// Ports:
//   clk            in   clock, rising edge
//   nrst           in   synchronous active-low reset
//   flush          in   empty everything on the next edge
//   accept         in   a payload is being taken from upstream this cycle
//   pop            in   the main entry is being consumed this cycle
//   in_ctrl        in   incoming control payload
//   in_data        in   incoming data payload
//   skid_valid     out  skid entry holds a payload (registered)
//   skid_ctrl      out  skid entry control payload
//   skid_data      out  skid entry data payload
//   occ            out  current occupancy (registered)
//   main_load_in   out  main entry must load the input this cycle
//   main_load_skid out  main entry must load the skid entry this cycle
//   main_clear     out  main entry empties this cycle
// -----------------------------------------------------------------------------
module pipereg_skid_buf
   import pipereg_pkg::*;
#(
   parameter int DATA_W = PIPEREG_DATA_W,
   parameter int CTRL_W = PIPEREG_CTRL_W
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              flush,
   input  logic              accept,
   input  logic              pop,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              skid_valid,
   output logic [CTRL_W-1:0] skid_ctrl,
   output logic [DATA_W-1:0] skid_data,
   output pipereg_occ_t      occ,
   output logic              main_load_in,
   output logic              main_load_skid,
   output logic              main_clear
);

   // Decode what the main entry has to do from the current occupancy and the
   // handshakes of this cycle. Flush priority is applied by the top level,
   // which overrides these strobes when flush is high. In OCC_TWO upstream is
   // blocked, so accept cannot occur there.
   always_comb begin
      main_load_in   = 1'b0;
      main_load_skid = 1'b0;
      main_clear     = 1'b0;
      unique case (occ)
         OCC_EMPTY: begin
            main_load_in = accept;
         end
         OCC_ONE: begin
            if (accept && pop) begin
               main_load_in = 1'b1;
            end else if (pop) begin
               main_clear = 1'b1;
            end
         end
         OCC_TWO: begin
            main_load_skid = pop;
         end
         default: begin
            main_clear = 1'b1;
         end
      endcase
   end

   // Occupancy FSM with the skid entry as its registered outputs. The skid
   // entry only fills when the main entry is busy and not draining, and it
   // hands its payload to the main entry as soon as downstream pops.
   // skid_valid is kept as its own flop so in_ready in the top is a pure
   // register output with no path from out_ready.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         occ        <= OCC_EMPTY;
         skid_valid <= 1'b0;
         skid_ctrl  <= '0;
         skid_data  <= '0;
      end else if (flush) begin
         occ        <= OCC_EMPTY;
         skid_valid <= 1'b0;
         skid_ctrl  <= '0;
         skid_data  <= '0;
      end else begin
         unique case (occ)
            OCC_EMPTY: begin
               if (accept) begin
                  occ <= OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (accept && !pop) begin
                  occ        <= OCC_TWO;
                  skid_valid <= 1'b1;
                  skid_ctrl  <= in_ctrl;
                  skid_data  <= in_data;
               end else if (!accept && pop) begin
                  occ <= OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               if (pop) begin
                  occ        <= OCC_ONE;
                  skid_valid <= 1'b0;
                  skid_ctrl  <= '0;
                  skid_data  <= '0;
               end
            end
            default: begin
               occ        <= OCC_EMPTY;
               skid_valid <= 1'b0;
               skid_ctrl  <= '0;
               skid_data  <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipereg_elastic.sv
// -----------------------------------------------------------------------------
// pipereg_elastic
// Elastic pipeline register for one stage boundary of the core. Carries a
// generic control + data payload with a valid/ready handshake, a flush that
// leaves a bubble, and a saturating count of backpressured cycles.
//
// Build option:
//   PIPEREG_SKID_EN  defined   -> two-entry skid buffer, in_ready registered
//                    undefined -> single entry, in_ready = !out_valid || out_ready
//
// Ports:
//   clk        in   clock, rising edge
//   nrst       in   synchronous active-low reset
//   flush      in   drop held entries and this cycle's input
//   in_valid   in   upstream offers a payload
//   in_ready   out  this block can take a payload this cycle
//   in_ctrl    in   control payload  [CTRL_W]
//   in_data    in   data payload     [DATA_W]
//   out_valid  out  held payload is valid
//   out_ready  in   downstream consumes this cycle
//   out_ctrl   out  control payload, zero whenever out_valid is low
//   out_data   out  data payload
//   stall_cnt  out  saturating count of backpressured cycles [CNT_W]
// -----------------------------------------------------------------------------
module pipereg_elastic
   import pipereg_pkg::*;
#(
   parameter int DATA_W = PIPEREG_DATA_W,
   parameter int CTRL_W = PIPEREG_CTRL_W,
   parameter int CNT_W  = PIPEREG_CNT_W
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              main_valid;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic              accept;
   logic              pop;

   // Flush wins over both handshakes, so an offer during flush is never taken.
   assign accept = in_valid && in_ready && !flush;
   assign pop    = main_valid && out_ready;

`ifdef PIPEREG_SKID_EN
   logic              skid_valid;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   pipereg_occ_t      occ;
   logic              main_load_in;
   logic              main_load_skid;
   logic              main_clear;

   pipereg_skid_buf #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_skid (
      .clk            (clk),
      .nrst           (nrst),
      .flush          (flush),
      .accept         (accept),
      .pop            (pop),
      .in_ctrl        (in_ctrl),
      .in_data        (in_data),
      .skid_valid     (skid_valid),
      .skid_ctrl      (skid_ctrl),
      .skid_data      (skid_data),
      .occ            (occ),
      .main_load_in   (main_load_in),
      .main_load_skid (main_load_skid),
      .main_clear     (main_clear)
   );

   // Upstream is only blocked once the spare slot is taken; this is a flop
   // output, which breaks the ready path between stages.
   assign in_ready   = !skid_valid;
   assign main_valid = (occ != OCC_EMPTY);

   // Main entry payload, steered by the FSM strobes. Output is always taken
   // from here; on drain the control is zeroed while data keeps its value.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         main_ctrl <= '0;
         main_data <= '0;
      end else if (flush) begin
         main_ctrl <= '0;
         main_data <= '0;
      end else if (main_load_in) begin
         main_ctrl <= in_ctrl;
         main_data <= in_data;
      end else if (main_load_skid) begin
         main_ctrl <= skid_ctrl;
         main_data <= skid_data;
      end else if (main_clear) begin
         main_ctrl <= '0;
      end
   end
`else
   // Single entry: a full register can still take a new payload in the same
   // cycle that downstream drains it, giving full throughput.
   assign in_ready = !main_valid || out_ready;

   // Single payload entry. Accept has priority over pop so a simultaneous
   // pop+accept simply replaces the contents.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         main_valid <= 1'b0;
         main_ctrl  <= '0;
         main_data  <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         main_ctrl  <= '0;
         main_data  <= '0;
      end else if (accept) begin
         main_valid <= 1'b1;
         main_ctrl  <= in_ctrl;
         main_data  <= in_data;
      end else if (pop) begin
         main_valid <= 1'b0;
         main_ctrl  <= '0;
      end
   end
`endif

   // Count every cycle upstream wanted to hand over a payload but was held
   // off. Flush cycles are excluded since the offer is dropped anyway. The
   // counter sticks at all-ones and is only cleared by reset.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         stall_cnt <= '0;
      end else if (in_valid && !in_ready && !flush && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   // Bubble masking: downstream may use control write enables ungated.
   assign out_valid = main_valid;
   assign out_ctrl  = main_valid ? main_ctrl : '0;
   assign out_data  = main_data;

endmodule
